// File: rtl/exhaustive_response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : exhaustive_response_checker
//  Description : Drives every N_IN-bit pattern into a single-output circuit
//                under test, compares each response against a preloaded
//                golden truth table and reports mismatch count, the lowest
//                failing pattern and a MISR signature of all responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module exhaustive_response_checker #(
    parameter int                N_IN      = 6,
    parameter int                SETTLE    = 1,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h8016
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              gold_load_valid,
    input  logic              gold_load_bit,
    output logic              gold_load_ready,
    output logic [0:N_IN-1]   pat,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     mismatch_cnt,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_idx,
    output logic [MISR_W-1:0] signature
);

    localparam int c_DEPTH  = 1 << N_IN;
    // Wait counter only needs to hold SETTLE-1; keep at least one bit.
    localparam int c_WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_RELOAD = c_WAIT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [c_DEPTH-1:0]  r_gold;
    logic [N_IN-1:0]     r_load_ptr;
    logic [N_IN-1:0]     r_idx;
    logic [c_WAIT_W-1:0] r_wait;
    logic [N_IN:0]       r_cnt;
    logic                r_ff_valid;
    logic [N_IN-1:0]     r_ff_idx;
    logic [MISR_W-1:0]   r_sig;

    logic                w_idle_or_done;
    logic                w_start_acc;
    logic                w_last_idx;
    logic                w_fail;
    logic [MISR_W-1:0]   w_sig_next;

    assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start_acc    = w_idle_or_done && start;
    assign w_last_idx     = (r_idx == {N_IN{1'b1}});
    assign w_fail         = dut_out ^ r_gold[r_idx];

    // Shift left, fold the feedback taps in when the MSB falls out, inject response in LSB
    assign w_sig_next = {r_sig[MISR_W-2:0], 1'b0}
                      ^ (r_sig[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}})
                      ^ {{(MISR_W-1){1'b0}}, dut_out};

    // pat[0] is the index MSB; a straight vector assignment preserves that ordering
    assign pat              = r_idx;
    assign mismatch_cnt     = r_cnt;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_idx   = r_ff_idx;
    assign signature        = r_sig;

    // State register
    always_ff @(posedge CK) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        w_next_state    = r_state;
        busy            = 1'b0;
        done            = 1'b0;
        gold_load_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                gold_load_ready = 1'b1;
                if (start) begin
                    w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (r_wait == '0) begin
                    w_next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                busy = 1'b1;
                w_next_state = w_last_idx ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                done            = 1'b1;
                gold_load_ready = 1'b1;
                if (start) begin
                    w_next_state = ST_SETTLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Golden table loading; a start in the same cycle wins and rewinds the pointer
    always_ff @(posedge CK) begin
        if (reset) begin
            r_gold     <= '0;
            r_load_ptr <= '0;
        end else if (w_start_acc) begin
            r_load_ptr <= '0;
        end else if (w_idle_or_done && gold_load_valid) begin
            r_gold[r_load_ptr] <= gold_load_bit;
            r_load_ptr         <= r_load_ptr + 1'b1;
        end
    end

    // Sweep datapath: pattern index, settle timer, compare, first-fail capture and MISR
    always_ff @(posedge CK) begin
        if (reset) begin
            r_idx      <= '0;
            r_wait     <= '0;
            r_cnt      <= '0;
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
            r_sig      <= '0;
        end else if (w_start_acc) begin
            r_idx      <= '0;
            r_wait     <= c_WAIT_RELOAD;
            r_cnt      <= '0;
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
            r_sig      <= '0;
        end else if (r_state == ST_SETTLE) begin
            if (r_wait != '0) begin
                r_wait <= r_wait - 1'b1;
            end
        end else if (r_state == ST_SAMPLE) begin
            r_sig <= w_sig_next;
            if (w_fail) begin
                r_cnt <= r_cnt + 1'b1;
                if (!r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_idx   <= r_idx;
                end
            end
            // Index stays on the last pattern once the sweep completes
            if (!w_last_idx) begin
                r_idx  <= r_idx + 1'b1;
                r_wait <= c_WAIT_RELOAD;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exhaustive_response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exhaustive_response_checker
//  Description : Directed and randomized bench for exhaustive_response_checker
//                with a table-level reference model of sweep results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exhaustive_response_checker;

    localparam int    c_N     = 6;
    localparam int    c_DEPTH = 64;
    localparam int    c_BOUND = 2000;

    logic        CK = 1'b0;
    logic        reset;

    // Instance with SETTLE=1
    logic        start1, gvalid1, gbit1, gready1, dut_out1, busy1, done1, ffv1;
    logic [0:5]  pat1;
    logic [6:0]  cnt1;
    logic [5:0]  ffi1;
    logic [15:0] sig1;

    // Instance with SETTLE=3, DUT response is the pattern LSB
    logic        start3, gready3, dut_out3, busy3, done3, ffv3;
    logic [0:5]  pat3;
    logic [6:0]  cnt3;
    logic [5:0]  ffi3;
    logic [15:0] sig3;

    int          checks   = 0;
    int          failures = 0;

    int          mode;
    logic [63:0] rtbl;
    bit          gm [c_DEPTH];
    int          gptr;

    always #5 CK = ~CK;

    // Behavioural circuits under test, selected by mode
    assign dut_out1 = (mode == 0) ? 1'b0 :
                      (mode == 1) ? (pat1 == 6'd37) :
                      (mode == 2) ? (pat1 == 6'd38) : rtbl[pat1];
    assign dut_out3 = pat3[5];

    exhaustive_response_checker #(.N_IN(6), .SETTLE(1), .MISR_W(16), .MISR_POLY(16'h8016)) u_dut1 (
        .CK(CK), .reset(reset), .start(start1),
        .gold_load_valid(gvalid1), .gold_load_bit(gbit1), .gold_load_ready(gready1),
        .pat(pat1), .dut_out(dut_out1), .busy(busy1), .done(done1),
        .mismatch_cnt(cnt1), .first_fail_valid(ffv1), .first_fail_idx(ffi1), .signature(sig1)
    );

    exhaustive_response_checker #(.N_IN(6), .SETTLE(3), .MISR_W(16), .MISR_POLY(16'h8016)) u_dut3 (
        .CK(CK), .reset(reset), .start(start3),
        .gold_load_valid(1'b0), .gold_load_bit(1'b0), .gold_load_ready(gready3),
        .pat(pat3), .dut_out(dut_out3), .busy(busy3), .done(done3),
        .mismatch_cnt(cnt3), .first_fail_valid(ffv3), .first_fail_idx(ffi3), .signature(sig3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit resp(input int m, input int i);
        case (m)
            0:       return 1'b0;
            1:       return (i == 37);
            2:       return (i == 38);
            3:       return rtbl[i];
            default: return i[0];
        endcase
    endfunction

    // Expected results of a full sweep: count, lowest failing index, MISR
    task automatic expect_sweep(input int m, input bit use_gold, output int cnt,
                                output int ff, output bit ffv, output logic [15:0] sig);
        cnt = 0; ff = 0; ffv = 0; sig = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            bit r;
            bit g;
            r = resp(m, i);
            g = use_gold ? gm[i] : 1'b0;
            if (r != g) begin
                if (!ffv) ff = i;
                ffv = 1;
                cnt++;
            end
            sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h8016 : 16'h0000) ^ {15'b0, r};
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic load_bits(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            gvalid1 = 1'b1;
            gbit1   = bits[i];
            step();
            gm[gptr] = bits[i];
            gptr     = (gptr + 1) % c_DEPTH;
        end
        gvalid1 = 1'b0;
        gbit1   = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input bit noise, input bit glitch);
        int cyc;
        bit saw_busy;
        start1 = 1'b1;
        if (glitch) begin
            gvalid1 = 1'b1;
            gbit1   = 1'b1;
        end
        step();
        start1  = 1'b0;
        gvalid1 = 1'b0;
        gptr    = 0;
        cyc      = 0;
        saw_busy = 1'b0;
        while (!done1 && cyc < c_BOUND) begin
            if (busy1 && !gready1) saw_busy = 1'b1;
            if (noise) begin
                gvalid1 = 1'($urandom % 2);
                gbit1   = 1'b1;
            end
            step();
            cyc++;
        end
        gvalid1 = 1'b0;
        gbit1   = 1'b0;
        check({tag, "_latency"}, cyc, 128);
        check({tag, "_busy_seen"}, saw_busy, 1);
        check({tag, "_pat_last"}, pat1, 63);
    endtask

    task automatic check_results(input string tag, input int m);
        int          e_cnt;
        int          e_ff;
        bit          e_ffv;
        logic [15:0] e_sig;
        expect_sweep(m, 1'b1, e_cnt, e_ff, e_ffv, e_sig);
        check({tag, "_cnt"}, cnt1, e_cnt);
        check({tag, "_ffv"}, ffv1, e_ffv);
        if (e_ffv) check({tag, "_ffi"}, ffi1, e_ff);
        check({tag, "_sig"}, sig1, e_sig);
    endtask

    initial begin
        int          cyc;
        logic [63:0] bits;
        int          e_cnt;
        int          e_ff;
        bit          e_ffv;
        logic [15:0] e_sig;

        reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
        gvalid1 = 1'b0; gbit1 = 1'b0; mode = 0; rtbl = '0; gptr = 0;
        for (int i = 0; i < c_DEPTH; i++) gm[i] = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_ready", gready1, 1);
        check("rst_cnt", cnt1, 0);
        check("rst_ffv", ffv1, 0);
        check("rst_sig", sig1, 0);
        check("rst_pat", pat1, 0);

        // Gold all 0, DUT tied 0
        mode = 0;
        run_sweep("zero", 1'b0, 1'b0);
        check("zero_done", done1, 1);
        check_results("zero", 0);

        // Gold all 1, DUT tied 0 (load in DONE)
        load_bits({64{1'b1}}, 64);
        run_sweep("ones", 1'b0, 1'b0);
        check_results("ones", 0);
        check("ones_ffi0", ffi1, 0);

        // Only bit 37 set
        bits = 64'd1 << 37;
        load_bits(bits, 64);
        mode = 1;
        run_sweep("m37", 1'b0, 1'b0);
        check("m37_cnt0", cnt1, 0);
        mode = 2;
        run_sweep("m38", 1'b0, 1'b0);
        check("m38_cnt2", cnt1, 2);
        check("m38_ffi", ffi1, 37);
        check_results("m38", 2);

        // Partial load of 10 bits, then loads while busy must be ignored
        bits = 64'h0000_0000_0000_02B6;
        load_bits(bits, 10);
        mode = 0;
        run_sweep("busyld", 1'b1, 1'b1);
        check_results("busyld", 0);
        // Pointer rewound on start: one bit lands at index 0
        load_bits(64'd1, 1);
        run_sweep("ptr0", 1'b0, 1'b0);
        check_results("ptr0", 0);

        // Randomized golden tables and DUT functions
        mode = 3;
        for (int t = 0; t < 3; t++) begin
            bits = {$urandom, $urandom};
            rtbl = {$urandom, $urandom};
            if (t == 1) rtbl = bits ^ (64'd1 << $urandom_range(63));
            load_bits(bits, 64);
            run_sweep($sformatf("rnd%0d", t), 1'b0, 1'b0);
            check_results($sformatf("rnd%0d", t), 3);
        end

        // Reset mid-sweep at index 20 clears everything including the table
        load_bits({$urandom, $urandom} | 64'h20, 64);
        mode  = 0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        cyc = 0;
        while (pat1 != 6'd20 && cyc < c_BOUND) begin
            step();
            cyc++;
        end
        check("reach_idx20", pat1, 20);
        reset = 1'b1;
        step();
        check("mid_busy", busy1, 0);
        check("mid_done", done1, 0);
        check("mid_ready", gready1, 1);
        check("mid_pat", pat1, 0);
        check("mid_cnt", cnt1, 0);
        check("mid_ffv", ffv1, 0);
        check("mid_ffi", ffi1, 0);
        check("mid_sig", sig1, 0);
        reset = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) gm[i] = 1'b0;
        gptr = 0;
        step();
        run_sweep("cleared", 1'b0, 1'b0);
        check_results("cleared", 0);

        // SETTLE=3 instance, DUT = pattern LSB, empty golden table
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        cyc = 0;
        while (!done3 && cyc < c_BOUND) begin
            step();
            cyc++;
        end
        expect_sweep(4, 1'b0, e_cnt, e_ff, e_ffv, e_sig);
        check("s3_latency", cyc, 256);
        check("s3_cnt", cnt3, e_cnt);
        check("s3_ffv", ffv3, e_ffv);
        check("s3_ffi", ffi3, e_ff);
        check("s3_sig", sig3, e_sig);
        check("s3_ready", gready3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
